// File: rtl/traffic_pkg.sv
// Shared widths, limits and helpers for the traffic sensor conditioner.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package traffic_pkg;

  localparam int HOLD_W           = 4;
  localparam int COUNT_W          = 8;
  localparam int COUNT_MAX        = 255;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

  // Increment that sticks at COUNT_MAX instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_W'(COUNT_MAX)) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One lane: 2-FF sync, level debounce, seconds hold-off, output flag, arrival counter.
// Latency: raw level to o_traffic is 2 sync + DEBOUNCE_CYCLES + 1 register edges.
// Backpressure: none; the raw input is sampled every cycle and never stalled.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_SECONDS    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_raw,
  input  logic               i_tick,
  input  logic               i_count_clr,
  output logic               o_traffic,
  output logic [COUNT_W-1:0] o_count
);

  // Counter only ever needs to hold 0..DEBOUNCE_CYCLES-1; +1 keeps width >= 1.
  localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SECONDS);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic [DB_W-1:0]    r_db_cnt;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_traffic;
  logic [COUNT_W-1:0] r_count;

  logic w_differ;
  logic w_accept;
  logic w_rise;

  assign w_differ = (r_sync2 != r_deb);
  // The debounced value flips on the edge where the count would reach DEBOUNCE_CYCLES.
  assign w_accept = w_differ && (r_db_cnt == DB_LAST);
  assign w_rise   = w_accept && r_sync2;

  // Two-flop synchronizer for the asynchronous detector input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level after DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb    <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_accept) begin
      r_deb    <= r_sync2;
      r_db_cnt <= '0;
    end else if (w_differ) begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Hold-off: reload while a vehicle is present, otherwise count seconds down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_deb) begin
      r_hold <= HOLD_LOAD;
    end else if (i_tick && (r_hold != '0)) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  // Registered traffic flag: present now or still inside the hold-off window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_traffic <= 1'b0;
    end else begin
      r_traffic <= r_deb | (r_hold != '0);
    end
  end

  // Saturating arrival counter; clear beats a same-cycle arrival.
  always_ff @(posedge clk) begin
    if (reset || i_count_clr) begin
      r_count <= '0;
    end else if (w_rise) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_traffic = r_traffic;
  assign o_count   = r_count;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions two lane vehicle detectors into traffic flags and counts, plus a 1 s tick.
// Latency: DEBOUNCE_CYCLES+3 edges raw-to-flag; tick_1s is decoded straight from the counter.
// Backpressure: none; both lanes run freely and independently every cycle.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int TICK_DIV        = DEFAULT_TICK_DIV,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_SECONDS    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_A_raw,
  input  logic               sensor_B_raw,
  input  logic               count_clr,
  output logic               traffic_A,
  output logic               traffic_B,
  output logic [COUNT_W-1:0] vehicle_count_A,
  output logic [COUNT_W-1:0] vehicle_count_B,
  output logic               tick_1s
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick  = (r_tick_cnt == TICK_LAST);
  assign tick_1s = w_tick;

  // Free-running 0..TICK_DIV-1 seconds prescaler, restarted by reset.
  always_ff @(posedge clk) begin
    if (reset || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_SECONDS    (HOLD_SECONDS)
  ) u_chan_a (
    .clk         (clk),
    .reset       (reset),
    .i_raw       (sensor_A_raw),
    .i_tick      (w_tick),
    .i_count_clr (count_clr),
    .o_traffic   (traffic_A),
    .o_count     (vehicle_count_A)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_SECONDS    (HOLD_SECONDS)
  ) u_chan_b (
    .clk         (clk),
    .reset       (reset),
    .i_raw       (sensor_B_raw),
    .i_tick      (w_tick),
    .i_count_clr (count_clr),
    .o_traffic   (traffic_B),
    .o_count     (vehicle_count_B)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: expected flag transitions are queued per lane
// with the edge they must appear on; a negedge monitor pops and compares each change.
// Counts and reset state are compared at quiet checkpoints against a small lane model.
module tb_traffic_sensor_conditioner;

  localparam int TICK_DIV = 3;
  localparam int DEB      = 4;
  localparam int HOLD     = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_A_raw;
  logic       sensor_B_raw;
  logic       count_clr;
  logic       traffic_A;
  logic       traffic_B;
  logic [7:0] vehicle_count_A;
  logic [7:0] vehicle_count_B;
  logic       tick_1s;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t  q_a[$];
  ev_t  q_b[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   rel    = 0;
  int   mdl_a  = 0;
  int   mdl_b  = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  traffic_sensor_conditioner #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_SECONDS    (HOLD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sensor_A_raw    (sensor_A_raw),
    .sensor_B_raw    (sensor_B_raw),
    .count_clr       (count_clr),
    .traffic_A       (traffic_A),
    .traffic_B       (traffic_B),
    .vehicle_count_A (vehicle_count_A),
    .vehicle_count_B (vehicle_count_B),
    .tick_1s         (tick_1s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // First cycle >= c in which tick_1s is high, counted from the last reset release.
  function automatic int next_tick(input int c);
    int t;
    t = c;
    while (((t - rel) % TICK_DIV) != TICK_DIV - 1) t++;
    return t;
  endfunction

  // Raw change driven just after edge e: flag rises after edge e+DEB+3.
  function automatic int rise_at(input int e);
    return e + DEB + 3;
  endfunction

  // Raw clear driven just after edge e: debounced value falls on edge e+DEB+2, then
  // HOLD ticks drain the hold counter; the flag drops one edge after the last tick edge.
  function automatic int fall_at(input int e);
    return next_tick(e + DEB + 2) + TICK_DIV * (HOLD - 1) + 2;
  endfunction

  task automatic push_a(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q_b.push_back(e);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_cntA"}, int'(vehicle_count_A), mdl_a);
    chk({tag, "_cntB"}, int'(vehicle_count_B), mdl_b);
  endtask

  // Monitor: every flag change must match the head of its lane queue.
  always @(negedge clk) begin
    ev_t e;
    if (traffic_A !== prev_a) begin
      if (q_a.size() == 0) begin
        chk("trafA_unexpected_change", cyc, -1);
      end else begin
        e = q_a.pop_front();
        chk("trafA_edge", cyc, e.cyc);
        chk("trafA_val", int'(traffic_A), e.val);
      end
      prev_a = traffic_A;
    end
    if (traffic_B !== prev_b) begin
      if (q_b.size() == 0) begin
        chk("trafB_unexpected_change", cyc, -1);
      end else begin
        e = q_b.pop_front();
        chk("trafB_edge", cyc, e.cyc);
        chk("trafB_val", int'(traffic_B), e.val);
      end
      prev_b = traffic_B;
    end
    if (!reset && (cyc >= rel) && (cyc < rel + 12))
      chk("tick_1s", int'(tick_1s), (((cyc - rel) % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
  end

  initial begin
    int e;
    int last;

    reset        = 1'b1;
    sensor_A_raw = 1'b0;
    sensor_B_raw = 1'b0;
    count_clr    = 1'b0;
    step(3);
    chk("rst_trafA", int'(traffic_A), 0);
    chk("rst_trafB", int'(traffic_B), 0);
    chk("rst_tick", int'(tick_1s), 0);
    chk_counts("rst");
    reset = 1'b0;
    rel   = cyc;
    step(4);

    // Lane A arrival: flag after edge E0+7, count 1, lane B untouched.
    e = cyc;
    sensor_A_raw = 1'b1;
    push_a(rise_at(e), 1);
    mdl_a++;
    step(12);
    chk("a_arrive_trafB", int'(traffic_B), 0);
    chk_counts("a_arrive");

    // Lane B glitch of 3 cycles: filtered out completely.
    sensor_B_raw = 1'b1;
    step(3);
    sensor_B_raw = 1'b0;
    step(12);
    chk_counts("b_glitch");
    chk("b_glitch_trafB", int'(traffic_B), 0);

    // Lane A release: flag held for HOLD ticks after the debounced fall.
    e = cyc;
    sensor_A_raw = 1'b0;
    push_a(fall_at(e), 0);
    step(20);

    // Re-assert during hold: debounced rise lands while hold is 1, flag never drops.
    e = cyc;
    sensor_A_raw = 1'b1;
    push_a(rise_at(e), 1);
    mdl_a++;
    step(12);
    while (((cyc - rel) % TICK_DIV) != 0) step(1);
    sensor_A_raw = 1'b0;
    step(5);
    sensor_A_raw = 1'b1;
    mdl_a++;
    step(15);
    chk("reassert_trafA", int'(traffic_A), 1);
    chk_counts("reassert");
    // Full hold after the reload proves the counter went back to HOLD.
    e = cyc;
    sensor_A_raw = 1'b0;
    push_a(fall_at(e), 0);
    step(20);

    // 300 back-to-back clean pulses: count saturates, flag stays up throughout.
    last = cyc;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) push_a(rise_at(cyc), 1);
      sensor_A_raw = 1'b1;
      mdl_a = (mdl_a < 255) ? mdl_a + 1 : 255;
      step(4);
      sensor_A_raw = 1'b0;
      last = cyc;
      step(4);
    end
    push_a(fall_at(last), 0);
    step(20);
    chk_counts("saturate");

    // count_clr on the same edge as a debounced rise: clear wins.
    e = cyc;
    sensor_A_raw = 1'b1;
    push_a(rise_at(e), 1);
    step(DEB + 1);
    count_clr = 1'b1;
    step(1);
    count_clr = 1'b0;
    mdl_a = 0;
    mdl_b = 0;
    step(3);
    chk_counts("clr_vs_rise");
    e = cyc;
    sensor_A_raw = 1'b0;
    push_a(fall_at(e), 0);
    step(20);

    // Simultaneous A and B events are processed in the same cycles.
    e = cyc;
    sensor_A_raw = 1'b1;
    sensor_B_raw = 1'b1;
    push_a(rise_at(e), 1);
    push_b(rise_at(e), 1);
    mdl_a++;
    mdl_b++;
    step(12);
    chk_counts("both_arrive");
    e = cyc;
    sensor_A_raw = 1'b0;
    sensor_B_raw = 1'b0;
    push_a(fall_at(e), 0);
    push_b(fall_at(e), 0);
    step(20);

    // Reset in the middle of the hold-off window aborts everything.
    e = cyc;
    sensor_A_raw = 1'b1;
    push_a(rise_at(e), 1);
    mdl_a++;
    step(12);
    chk_counts("pre_reset");
    e = cyc;
    sensor_A_raw = 1'b0;
    step(DEB + 3);
    reset = 1'b1;
    push_a(e + DEB + 4, 0);
    step(1);
    chk("midhold_rst_trafA", int'(traffic_A), 0);
    chk("midhold_rst_trafB", int'(traffic_B), 0);
    chk("midhold_rst_tick", int'(tick_1s), 0);
    mdl_a = 0;
    mdl_b = 0;
    chk_counts("midhold_rst");
    reset = 1'b0;
    rel   = cyc;
    step(20);
    chk("post_rst_trafA", int'(traffic_A), 0);
    chk_counts("post_rst");

    chk("queueA_drained", q_a.size(), 0);
    chk("queueB_drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
